// File: rtl/br_pred_pkg.sv
// Shared branch-predictor definitions: resolve encodings, saturating-counter helpers
// and the init/run FSM state used by the direction predictors.
package br_pred_pkg;

    localparam int BR_STATE_W = 2;

    localparam logic [BR_STATE_W-1:0] BR_NONE       = 2'd0;
    localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = 2'd1;
    localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = 2'd2;

    // Widest counter the helpers support; callers truncate back to their own CNT_W.
    localparam int CNT_MAX_W = 8;
    typedef logic [CNT_MAX_W-1:0] cnt_t;

    typedef enum logic {
        INIT,
        RUN
    } dirp_state_e;

    function automatic cnt_t cnt_max(input int cnt_w);
        cnt_t all_ones;
        all_ones = '1;
        return all_ones >> (CNT_MAX_W - cnt_w);
    endfunction

    function automatic cnt_t sat_inc(input cnt_t cnt, input int cnt_w);
        return (cnt >= cnt_max(cnt_w)) ? cnt_max(cnt_w) : cnt + cnt_t'(1);
    endfunction

    function automatic cnt_t sat_dec(input cnt_t cnt, input int cnt_w);
        return (cnt == '0) ? '0 : cnt - cnt_t'(1);
    endfunction

endpackage

// File: rtl/dirp_pht.sv
// Pattern history table: one async read port for prediction, one sync write port
// shared between the init sweep and the resolve-time counter update.
module dirp_pht
    import br_pred_pkg::*;
#(
    parameter int BHR_W = 8,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic [BHR_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             sweep_en,
    input  logic [BHR_W-1:0] sweep_idx,
    input  logic [CNT_W-1:0] sweep_cnt,
    input  logic             upd_en,
    input  logic [BHR_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << BHR_W;

    logic [CNT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] upd_cur;
    logic [CNT_W-1:0] upd_nxt;
    logic             wr_en;
    logic [BHR_W-1:0] wr_idx;
    logic [CNT_W-1:0] wr_cnt;

    assign rd_cnt  = mem[rd_idx];
    assign upd_cur = mem[upd_idx];
    assign upd_nxt = upd_taken ? CNT_W'(sat_inc(cnt_t'(upd_cur), CNT_W))
                               : CNT_W'(sat_dec(cnt_t'(upd_cur), CNT_W));

    assign wr_en  = sweep_en | upd_en;
    assign wr_idx = sweep_en ? sweep_idx : upd_idx;
    assign wr_cnt = sweep_en ? sweep_cnt : upd_nxt;

    // NOTE: the table has no reset; the INIT sweep writes every entry before rdy_o rises.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_cnt;
        end
    end

endmodule

// File: rtl/gshare_dirp.sv
// Global-history direction predictor with speculative BHR, mispredict recovery and PHT init sweep.
// Define DIRP_GSHARE_XOR_EN for gshare (PC xor history) indexing; otherwise GAg (history only).
module gshare_dirp
    import br_pred_pkg::*;
#(
    parameter int BHR_W    = 8,
    parameter int CNT_W    = 2,
    parameter int PC_LSB   = 2,
    parameter int CNT_INIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_br_i,
    input  logic [31:0]           pc_i,
    output logic                  pred_o,
    output logic [BHR_W-1:0]      save_bhr_o,
    output logic                  rdy_o,
    input  logic [BR_STATE_W-1:0] reslv_i,
    input  logic [31:0]           reslv_pc_i,
    input  logic [BHR_W-1:0]      reslv_bhr_i,
    input  logic                  reslv_taken_i
);

    localparam int               DEPTH    = 1 << BHR_W;
    localparam logic [BHR_W-1:0] LAST_IDX = BHR_W'(DEPTH - 1);

    dirp_state_e      state;
    logic [BHR_W-1:0] sweep_idx;
    logic [BHR_W-1:0] bhr;
    logic [BHR_W-1:0] pred_idx;
    logic [BHR_W-1:0] upd_idx;
    logic [CNT_W-1:0] pred_cnt;
    logic             reslv_vld;
    logic             reslv_wrong;
    logic             unused_pc;

    // Reserved encoding 2'b11 falls out of both compares and behaves as BR_NONE.
    assign reslv_vld   = (reslv_i == BR_PR_CORRECT) || (reslv_i == BR_PR_WRONG);
    assign reslv_wrong = (reslv_i == BR_PR_WRONG);

`ifdef DIRP_GSHARE_XOR_EN
    assign pred_idx = pc_i[PC_LSB +: BHR_W] ^ bhr;
    assign upd_idx  = reslv_pc_i[PC_LSB +: BHR_W] ^ reslv_bhr_i;
`else
    assign pred_idx = bhr;
    assign upd_idx  = reslv_bhr_i;
`endif
    assign unused_pc = ^{pc_i, reslv_pc_i};

    dirp_pht #(
        .BHR_W(BHR_W),
        .CNT_W(CNT_W)
    ) u_pht (
        .clk      (clk),
        .rd_idx   (pred_idx),
        .rd_cnt   (pred_cnt),
        .sweep_en (state == INIT && !rst),
        .sweep_idx(sweep_idx),
        .sweep_cnt(CNT_W'(CNT_INIT)),
        .upd_en   (state == RUN && reslv_vld && !rst),
        .upd_idx  (upd_idx),
        .upd_taken(reslv_taken_i)
    );

    assign pred_o     = rdy_o & pred_cnt[CNT_W-1];
    assign save_bhr_o = bhr;

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            rdy_o     <= 1'b0;
            sweep_idx <= '0;
            bhr       <= '0;
        end else begin
            case (state)
                INIT: begin
                    sweep_idx <= sweep_idx + BHR_W'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state <= RUN;
                        rdy_o <= 1'b1;
                    end
                end
                RUN: begin
                    // A mispredict flushes fetch, so its recovery overrides any same-cycle shift.
                    if (reslv_wrong) begin
                        bhr <= {reslv_bhr_i[BHR_W-2:0], reslv_taken_i};
                    end else if (is_br_i) begin
                        bhr <= {bhr[BHR_W-2:0], pred_o};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_dirp.sv
// Scoreboard bench for gshare_dirp: directed corner cases plus random traffic against
// a counter-array model. Define DIRP_GSHARE_XOR_EN to check gshare indexing, else GAg.
`timescale 1ns/1ps
module tb_gshare_dirp;
    import br_pred_pkg::*;

    localparam int BHR_W     = 8;
    localparam int CNT_W     = 2;
    localparam int PC_LSB    = 2;
    localparam int CNT_INIT  = 1;
    localparam int DEPTH     = 1 << BHR_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int TAKEN_MIN = 1 << (CNT_W - 1);
`ifdef DIRP_GSHARE_XOR_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic             clk           = 1'b0;
    logic             rst           = 1'b1;
    logic             is_br_i       = 1'b0;
    logic [31:0]      pc_i          = '0;
    logic             pred_o;
    logic [BHR_W-1:0] save_bhr_o;
    logic             rdy_o;
    logic [1:0]       reslv_i       = BR_NONE;
    logic [31:0]      reslv_pc_i    = '0;
    logic [BHR_W-1:0] reslv_bhr_i   = '0;
    logic             reslv_taken_i = 1'b0;

    gshare_dirp #(
        .BHR_W(BHR_W), .CNT_W(CNT_W), .PC_LSB(PC_LSB), .CNT_INIT(CNT_INIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .is_br_i      (is_br_i),
        .pc_i         (pc_i),
        .pred_o       (pred_o),
        .save_bhr_o   (save_bhr_o),
        .rdy_o        (rdy_o),
        .reslv_i      (reslv_i),
        .reslv_pc_i   (reslv_pc_i),
        .reslv_bhr_i  (reslv_bhr_i),
        .reslv_taken_i(reslv_taken_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: plain counter array, history as an integer, init as a countdown.
    int  m_pht [DEPTH];
    int  m_bhr  = 0;
    int  m_left = DEPTH;
    bit  mon_en = 1'b0;

    typedef struct {
        int pred;
        int bhr;
    } exp_t;
    exp_t sb_q[$];

    function automatic int m_idx(input logic [31:0] pc, input int h);
        int pc_part;
        pc_part = int'((pc >> PC_LSB) % DEPTH);
        return GSHARE ? (pc_part ^ h) : h;
    endfunction

    function automatic int m_pred(input logic [31:0] pc);
        return (m_pht[m_idx(pc, m_bhr)] >= TAKEN_MIN) ? 1 : 0;
    endfunction

    task automatic drive(input logic br, input logic [31:0] pc, input logic [1:0] rs,
                         input logic [31:0] rpc, input logic [BHR_W-1:0] rbhr, input logic rt);
        is_br_i       = br;
        pc_i          = pc;
        reslv_i       = rs;
        reslv_pc_i    = rpc;
        reslv_bhr_i   = rbhr;
        reslv_taken_i = rt;
        #1;
    endtask

    task automatic drive_rand();
        int         r;
        logic [1:0] rs;
        r  = int'($urandom_range(0, 7));
        rs = (r < 4) ? BR_NONE : (r < 6) ? BR_PR_CORRECT : (r == 6) ? BR_PR_WRONG : 2'b11;
        drive(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 15) * 4), rs,
              32'h1000 + 32'($urandom_range(0, 15) * 4), 8'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)));
    endtask

    // Push the expected response for this cycle, advance one edge, then update the model.
    task automatic tick();
        int   p;
        int   i;
        exp_t e;
        p = m_pred(pc_i);
        if (m_left == 0 && is_br_i) begin
            e.pred = p;
            e.bhr  = m_bhr;
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_left = DEPTH;
            m_bhr  = 0;
            foreach (m_pht[k]) m_pht[k] = CNT_INIT;
        end else if (m_left > 0) begin
            m_left--;
        end else begin
            if (reslv_i == BR_PR_CORRECT || reslv_i == BR_PR_WRONG) begin
                i = m_idx(reslv_pc_i, int'(reslv_bhr_i));
                if (reslv_taken_i) m_pht[i] = (m_pht[i] < CNT_MAX) ? m_pht[i] + 1 : CNT_MAX;
                else               m_pht[i] = (m_pht[i] > 0) ? m_pht[i] - 1 : 0;
            end
            if (reslv_i == BR_PR_WRONG) m_bhr = (int'(reslv_bhr_i) * 2 + int'(reslv_taken_i)) % DEPTH;
            else if (is_br_i)           m_bhr = (m_bhr * 2 + p) % DEPTH;
        end
        #1;
    endtask

    task automatic probe(input logic [31:0] pc);
        drive(1'b0, pc, BR_NONE, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic predict(input logic [31:0] pc);
        drive(1'b1, pc, BR_NONE, 32'h0, 8'h00, 1'b0);
        tick();
    endtask

    task automatic resolve(input logic [1:0] rs, input logic [BHR_W-1:0] rbhr, input logic rt);
        drive(1'b0, 32'h1000, rs, 32'h1000, rbhr, rt);
        tick();
    endtask

    task automatic wait_rdy(input string name, input int exp_cycles, input bit noisy);
        int n;
        n = 0;
        while (!rdy_o && n < 1000) begin
            if (noisy) drive_rand();
            tick();
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    // Monitor: compares every presented prediction against the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("rdy", int'(rdy_o), int'(m_left == 0));
                if (m_left != 0) check("init_outputs_zero", int'({pred_o, save_bhr_o}), 0);
                if (is_br_i && rdy_o) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL sb_unexpected: prediction presented with no expectation queued at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_pred", int'(pred_o), e.pred);
                        check("sb_bhr", int'(save_bhr_o), e.bhr);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq[3] = '{0, 1, 3};

        probe(32'h0);
        rst = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        rst    = 1'b0;
        wait_rdy("init_cycles", 256, 1'b0);
        probe(32'h1000);
        check("ready_pred", int'(pred_o), 0);
        check("ready_bhr", int'(save_bhr_o), 0);

        for (int i = 0; i < DEPTH; i++) predict(32'(i * 4));
        probe(32'h1000);
        check("bhr_after_nt_sweep", int'(save_bhr_o), 0);

        // Counter saturation at entry 0 (PC 0x1000, history 0 index entry 0 in both modes).
        resolve(BR_PR_CORRECT, 8'h00, 1'b1);
        resolve(BR_PR_CORRECT, 8'h00, 1'b1);
        probe(32'h1000);
        check("cnt_two_taken", int'(pred_o), 1);
        resolve(BR_PR_CORRECT, 8'h00, 1'b1);
        resolve(BR_PR_CORRECT, 8'h00, 1'b0);
        probe(32'h1000);
        check("cnt_sat_hi_then_nt", int'(pred_o), 1);
        resolve(BR_PR_CORRECT, 8'h00, 1'b0);
        probe(32'h1000);
        check("cnt_down_to_1", int'(pred_o), 0);
        resolve(BR_PR_CORRECT, 8'h00, 1'b0);
        resolve(BR_PR_CORRECT, 8'h00, 1'b0);
        resolve(BR_PR_CORRECT, 8'h00, 1'b1);
        probe(32'h1000);
        check("cnt_sat_lo_then_t", int'(pred_o), 0);

        // History shifts: not-taken predictions keep BHR at 0, then seeded taken path 1,3,7.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h1000, BR_NONE, 32'h0, 8'h00, 1'b0);
            check("bhr_nt_shift", int'(save_bhr_o), 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            resolve(BR_PR_CORRECT, 8'(exp_seq[k]), 1'b1);
            resolve(BR_PR_CORRECT, 8'(exp_seq[k]), 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h1000, BR_NONE, 32'h0, 8'h00, 1'b0);
            check("bhr_taken_shift", int'(save_bhr_o), exp_seq[k]);
            tick();
        end
        probe(32'h1000);
        check("bhr_after_three_taken", int'(save_bhr_o), 8'h07);

        resolve(BR_PR_CORRECT, 8'hFF, 1'b1);
        resolve(BR_PR_CORRECT, 8'hFF, 1'b1);
        resolve(BR_PR_WRONG, 8'h7F, 1'b1);
        probe(32'h1000);
        check("recover_to_ff", int'(save_bhr_o), 8'hFF);
        predict(32'h1000);
        probe(32'h1000);
        check("bhr_ff_taken", int'(save_bhr_o), 8'hFF);
        resolve(BR_PR_WRONG, 8'h40, 1'b0);
        predict(32'h1000);
        probe(32'h1000);
        check("bhr_msb_drop", int'(save_bhr_o), 8'h00);

        // Recovery wins over a same-cycle fetch shift; a correct resolve leaves BHR alone.
        drive(1'b1, 32'h1000, BR_PR_WRONG, 32'h1000, 8'h5A, 1'b1);
        tick();
        probe(32'h1000);
        check("recover_priority", int'(save_bhr_o), 8'hB5);
        resolve(BR_PR_CORRECT, 8'h33, 1'b0);
        probe(32'h1000);
        check("correct_keeps_bhr", int'(save_bhr_o), 8'hB5);

        // Same-cycle read of an entry being updated returns the old counter.
        drive(1'b0, 32'h1000, BR_PR_CORRECT, 32'h1000, 8'hB5, 1'b1);
        check("same_cycle_old", int'(pred_o), 0);
        tick();
        probe(32'h1000);
        check("next_cycle_new", int'(pred_o), 1);
        probe(32'h1004);
        check("pc_alias", int'(pred_o), GSHARE ? 0 : 1);

        for (int c = 0; c < 1500; c++) begin
            drive_rand();
            tick();
        end

        // Reset from RUN, then again 100 cycles into the sweep.
        rst = 1'b1;
        drive_rand();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive_rand();
            tick();
        end
        rst = 1'b1;
        probe(32'h0);
        tick();
        rst = 1'b0;
        wait_rdy("resweep_cycles", 256, 1'b1);
        probe(32'h1000);
        check("resweep_bhr", int'(save_bhr_o), 0);
        for (int c = 0; c < 300; c++) begin
            drive_rand();
            tick();
        end

        probe(32'h0);
        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gshare_dirp.md
Name: gshare_dirp

Overview:
- Parametrised global-history direction predictor; successor to the fixed 2-bit, BHR-indexed predictor.
- Sits in the fetch stage beside the BTB and supplies a taken/not-taken prediction per fetched branch.
- Generalised in history length and counter width; indexes the PHT with PC xor history.
- Adds a speculative BHR with mispredict recovery from a per-branch snapshot, plus a reset-sweep FSM that initialises the PHT.

Parameters:
- BHR_W, 8, global history length in bits; PHT depth = 2**BHR_W.
- CNT_W, 2, saturating counter width (>=2); prediction = counter MSB.
- PC_LSB, 2, lowest PC bit used for indexing (drops byte offset).
- CNT_INIT, 1, counter reset value (weakly not-taken for CNT_W=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- is_br_i  in  1  fetched instruction is a conditional branch this cycle
- pc_i  in  32  fetch PC of that branch
- pred_o  out  1  predicted direction (valid when is_br_i && rdy_o)
- save_bhr_o  out  BHR_W  BHR before this branch's shift; carried with the branch to resolve
- rdy_o  out  1  predictor initialised; fetch must not present branches while low
- reslv_i  in  2  BR_NONE / BR_PR_CORRECT / BR_PR_WRONG
- reslv_pc_i  in  32  PC of the resolving branch
- reslv_bhr_i  in  BHR_W  save_bhr_o captured when that branch was predicted
- reslv_taken_i  in  1  actual direction of the resolving branch

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
- Index: idx = pc[PC_LSB+BHR_W-1:PC_LSB] ^ BHR for predict, and the same with reslv_pc_i/reslv_bhr_i for update.
- Predict: combinational.
  - pred_o = PHT[idx][CNT_W-1].
  - save_bhr_o = current BHR.
  - Zero-cycle latency.
- Speculative BHR:
  - On is_br_i && rdy_o, next BHR = {BHR[BHR_W-2:0], pred_o}.
  - The MSB is dropped on every shift (no wrap state).
- Recovery:
  - reslv_i==BR_PR_WRONG sets next BHR = {reslv_bhr_i[BHR_W-2:0], reslv_taken_i}.
  - Recovery has priority over a same-cycle is_br_i, whose shift is discarded because the front end is flushing.
  - BR_PR_CORRECT leaves BHR untouched.
- PHT update: on any reslv_i != BR_NONE, counter at the resolve idx moves:
  - +1 if taken, saturating at 2**CNT_W-1;
  - -1 if not taken, saturating at 0.
  - The update is visible next cycle. A same-cycle predict read of the same entry returns the old value (no bypass).
- FSM states INIT, RUN:
  - rst enters INIT with sweep counter 0, BHR=0, rdy_o=0.
  - INIT writes CNT_INIT to one PHT entry per cycle, increments the counter, and moves to RUN after entry 2**BHR_W-1 (2**BHR_W cycles).
  - RUN: rdy_o=1.
  - rst asserted mid-sweep restarts the sweep from entry 0.
  - In INIT, reslv_i and is_br_i are ignored and BHR stays 0.
- Reset values:
  - rdy_o=0; save_bhr_o=0.
  - pred_o is undefined-safe: forced 0 while !rdy_o.
- Reserved encoding reslv_i==2'b11 is treated as BR_NONE.

Optional Feature:
- Macro DIRP_GSHARE_XOR_EN.
- Defined: gshare indexing as above.
- Undefined: GAg indexing with idx = BHR only (predict) or reslv_bhr_i (update); pc_i and reslv_pc_i are unused. All other behaviour is identical.

Decomposition:
- Shared package br_pred_pkg:
  - BR_STATE_W=2;
  - BR_NONE=0, BR_PR_CORRECT=1, BR_PR_WRONG=2;
  - counter helper functions sat_inc/sat_dec parameterised on CNT_W;
  - FSM enum {INIT, RUN}.
- One sub-module dirp_pht:
  - PHT storage with one async read port and one sync write port;
  - write mux selects sweep vs. update;
  - parameters BHR_W, CNT_W.

Test Plan:
- Reset, then hold idle -> rdy_o low for exactly 256 cycles (BHR_W=8), then high; every entry reads counter 1, pred_o=0.
- PC 0x1000 resolved taken 2x with reslv_bhr_i=0, then predicted with BHR=0 -> counter 1->2->3, pred_o=1. A third taken resolve keeps it at 3; three not-taken resolves drive it to 0 and it stays 0.
- Three branches predicted while the PHT is all-NT -> BHR goes 0x00->0x00; after seeding taken, 0x01->0x03->0x07. BHR 0xFF plus a taken shift gives 0xFF; BHR 0x80 plus a not-taken shift gives 0x00 (MSB dropped).
- BR_PR_WRONG with reslv_bhr_i=0x5A, taken=1, same cycle as is_br_i -> next BHR=0xB5 and the fetch shift is discarded. BR_PR_CORRECT -> BHR unchanged.
- Resolve and predict hit the same idx in one cycle -> pred_o reflects the pre-update counter; the next cycle reflects the updated counter.
- rst pulsed at sweep cycle 100 -> rdy_o stays low for 256 further cycles.
- Same tests compiled without DIRP_GSHARE_XOR_EN -> different PCs with equal BHR alias to the same counter.
